dispatch_npc_ctl: RTL and testbench

- Consumer stage directly downstream of the dispatch RAM in the CADR microsequencer.
- Takes the registered dispatch word {dr, dp, dn, dpc} and resolves the next micro-PC (jump, call, return or fall-through). Drives the NOP-next-instruction inhibit.
- Owns the 32-entry SPC micro-return stack, including sticky overflow/underflow tracking.
- Also services non-dispatch SPC push/pop traffic from the rest of the datapath.

---
 rtl/dispatch_npc_ctl.sv | 228 ++++++++++++++++++++++
 tb/tb_dispatch_npc_ctl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_npc_ctl.sv
// dispatch_npc_ctl: resolves the next micro-PC from the registered dispatch
// word {dr, dp, dn, dpc}, drives the NOP-next inhibit, and owns the 32-entry
// SPC micro-return stack with sticky overflow/underflow flags. Outside the
// RESOLVE cycle the stack serves external push/pop traffic.
module dispatch_npc_ctl #(
  parameter int PC_W         = 14,
  parameter int SPC_W        = 19,
  parameter int SPC_DEPTH_LG = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    disp_req,
  input  logic [PC_W-1:0]         pc,
  input  logic                    dr,
  input  logic                    dp,
  input  logic                    dn,
  input  logic [PC_W-1:0]         dpc,
  output logic                    disp_ready,
  output logic [PC_W-1:0]         npc,
  output logic                    npc_valid,
  output logic                    inhibit,
  input  logic                    spc_push,
  input  logic                    spc_pop,
  input  logic [SPC_W-1:0]        spc_wdata,
  output logic                    spc_busy,
  output logic [SPC_W-1:0]        spc_top,
  output logic [SPC_DEPTH_LG-1:0] spc_ptr,
  output logic                    spc_ovf,
  output logic                    spc_unf,
  input  logic                    err_clr
);

  localparam int DEPTH = 1 << SPC_DEPTH_LG;
  localparam int CNT_W = SPC_DEPTH_LG + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RESOLVE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Dispatch holding registers (data only, never reset)
  logic [PC_W-1:0] ret_q, ret_d;
  logic [PC_W-1:0] dpc_q, dpc_d;
  logic            dr_q, dr_d;
  logic            dp_q, dp_d;
  logic            dn_q, dn_d;

  // Outputs and stack control state
  logic [PC_W-1:0]         npc_q, npc_d;
  logic                    inhibit_q, inhibit_d;
  logic                    npc_valid_q, npc_valid_d;
  logic [SPC_DEPTH_LG-1:0] sp_q, sp_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic                    unf_q, unf_d;

  // Stack storage and its single write port
  logic [SPC_W-1:0]        stack_mem [DEPTH];
  logic                    stk_we;
  logic [SPC_DEPTH_LG-1:0] stk_waddr;
  logic [SPC_W-1:0]        stk_wdata;

  logic             do_push;
  logic             do_pop;
  logic [SPC_W-1:0] push_data;

  // Count tracks live entries, saturating at the stack depth on push
  function automatic logic [CNT_W-1:0] cnt_push(input logic [CNT_W-1:0] c);
    return (c == CNT_FULL) ? c : c + CNT_W'(1);
  endfunction

  // Count never drops below zero; a pop of an empty stack keeps it at zero
  function automatic logic [CNT_W-1:0] cnt_pop(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state: a dispatch always takes WAIT then RESOLVE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (disp_req) state_d = S_WAIT;
      S_WAIT:    state_d = S_RESOLVE;
      S_RESOLVE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs: accept dispatches only in IDLE, lock out external stack ops in RESOLVE
  always_comb begin
    disp_ready = (state_q == S_IDLE);
    spc_busy   = (state_q == S_RESOLVE);
  end

  // Datapath next-state: dispatch capture, action decode and stack update
  always_comb begin
    ret_d       = ret_q;
    dpc_d       = dpc_q;
    dr_d        = dr_q;
    dp_d        = dp_q;
    dn_d        = dn_q;
    npc_d       = npc_q;
    inhibit_d   = inhibit_q;
    npc_valid_d = 1'b0;
    sp_d        = sp_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    stk_we      = 1'b0;
    stk_waddr   = sp_q;
    stk_wdata   = '0;
    do_push     = 1'b0;
    do_pop      = 1'b0;
    push_data   = '0;

    if ((state_q == S_IDLE) && disp_req) ret_d = pc + PC_W'(1);

    if (state_q == S_WAIT) begin
      dr_d  = dr;
      dp_d  = dp;
      dn_d  = dn;
      dpc_d = dpc;
    end

    if (state_q == S_RESOLVE) begin
      npc_valid_d = 1'b1;
      inhibit_d   = dn_q;
      unique case ({dr_q, dp_q})
        2'b00: npc_d = dpc_q;
        2'b01: begin
          npc_d     = dpc_q;
          do_push   = 1'b1;
          push_data = {{(SPC_W-PC_W){1'b0}}, ret_q};
        end
        2'b10: begin
          npc_d  = stack_mem[sp_q][PC_W-1:0];
          do_pop = 1'b1;
        end
        default: npc_d = ret_q;
      endcase
    end else begin
      // Simultaneous push and pop replaces the top in place
      if (spc_push && spc_pop) begin
        stk_we    = 1'b1;
        stk_waddr = sp_q;
        stk_wdata = spc_wdata;
      end else if (spc_push) begin
        do_push   = 1'b1;
        push_data = spc_wdata;
      end else if (spc_pop) begin
        do_pop = 1'b1;
      end
    end

    if (do_push) begin
      sp_d      = sp_q + SPC_DEPTH_LG'(1);
      stk_we    = 1'b1;
      stk_waddr = sp_q + SPC_DEPTH_LG'(1);
      stk_wdata = push_data;
      count_d   = cnt_push(count_q);
      if (count_q == CNT_FULL) ovf_d = 1'b1;
    end

    if (do_pop) begin
      sp_d    = sp_q - SPC_DEPTH_LG'(1);
      count_d = cnt_pop(count_q);
      if (count_q == '0) unf_d = 1'b1;
    end

    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      npc_q       <= '0;
      inhibit_q   <= 1'b0;
      npc_valid_q <= 1'b0;
      sp_q        <= '1;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      npc_q       <= npc_d;
      inhibit_q   <= inhibit_d;
      npc_valid_q <= npc_valid_d;
      sp_q        <= sp_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  // Dispatch holding registers carry no reset
  always_ff @(posedge clk) begin
    ret_q <= ret_d;
    dpc_q <= dpc_d;
    dr_q  <= dr_d;
    dp_q  <= dp_d;
    dn_q  <= dn_d;
  end

  // Stack array write port; contents survive reset
  always_ff @(posedge clk) begin
    if (stk_we) stack_mem[stk_waddr] <= stk_wdata;
  end

  assign npc       = npc_q;
  assign npc_valid = npc_valid_q;
  assign inhibit   = inhibit_q;
  assign spc_top   = stack_mem[sp_q];
  assign spc_ptr   = sp_q;
  assign spc_ovf   = ovf_q;
  assign spc_unf   = unf_q;

endmodule

// File: tb/tb_dispatch_npc_ctl.sv
// Bench for dispatch_npc_ctl: a stack model and an expected-result queue for
// dispatch outcomes, checked when npc_valid pulses.
module tb_dispatch_npc_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic        disp_req;
  logic [13:0] pc;
  logic        dr, dp, dn;
  logic [13:0] dpc;
  logic        disp_ready;
  logic [13:0] npc;
  logic        npc_valid;
  logic        inhibit;
  logic        spc_push, spc_pop;
  logic [18:0] spc_wdata;
  logic        spc_busy;
  logic [18:0] spc_top;
  logic [4:0]  spc_ptr;
  logic        spc_ovf, spc_unf;
  logic        err_clr;

  int n_chk  = 0;
  int n_fail = 0;

  // Expected {inhibit, npc} per dispatch
  logic [14:0] exp_q [$];

  // Stack reference model
  logic [18:0] mstack [32];
  bit          mvalid [32];
  int          msp;
  int          mcount;
  bit          movf, munf;

  dispatch_npc_ctl dut (
    .clk        (clk),
    .reset      (reset),
    .disp_req   (disp_req),
    .pc         (pc),
    .dr         (dr),
    .dp         (dp),
    .dn         (dn),
    .dpc        (dpc),
    .disp_ready (disp_ready),
    .npc        (npc),
    .npc_valid  (npc_valid),
    .inhibit    (inhibit),
    .spc_push   (spc_push),
    .spc_pop    (spc_pop),
    .spc_wdata  (spc_wdata),
    .spc_busy   (spc_busy),
    .spc_top    (spc_top),
    .spc_ptr    (spc_ptr),
    .spc_ovf    (spc_ovf),
    .spc_unf    (spc_unf),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    msp    = 31;
    mcount = 0;
    movf   = 1'b0;
    munf   = 1'b0;
  endtask

  task automatic m_push(input logic [18:0] d);
    msp = (msp + 1) % 32;
    mstack[msp] = d;
    mvalid[msp] = 1'b1;
    if (mcount < 32) mcount++;
    else movf = 1'b1;
  endtask

  task automatic m_pop(output logic [18:0] d);
    d   = mstack[msp];
    msp = (msp + 31) % 32;
    if (mcount > 0) mcount--;
    else munf = 1'b1;
  endtask

  task automatic chk_state(input string tag);
    check_eq({tag, "_ptr"}, 32'(spc_ptr), 32'(msp));
    check_eq({tag, "_ovf"}, 32'(spc_ovf), 32'(movf));
    check_eq({tag, "_unf"}, 32'(spc_unf), 32'(munf));
    if (mvalid[msp]) check_eq({tag, "_top"}, 32'(spc_top), 32'(mstack[msp]));
  endtask

  // One dispatch; disp_req is deliberately held through WAIT to show it is ignored.
  // With hold_push, an external push is raised in RESOLVE and left asserted.
  task automatic dispatch(input logic [13:0] p, input bit r, input bit pp, input bit n,
                          input logic [13:0] t, input bit hold_push, input logic [18:0] hd);
    logic [13:0] ret;
    logic [13:0] exp_npc;
    logic [18:0] x;
    @(negedge clk);
    check_eq("rdy_idle", 32'(disp_ready), 32'd1);
    disp_req = 1'b1;
    pc       = p;
    @(negedge clk);
    check_eq("rdy_wait", 32'(disp_ready), 32'd0);
    dr  = r;
    dp  = pp;
    dn  = n;
    dpc = t;
    pc  = 14'h0;
    ret = p + 14'd1;
    case ({r, pp})
      2'b00:   exp_npc = t;
      2'b01:   begin m_push({5'b0, ret}); exp_npc = t; end
      2'b10:   begin m_pop(x); exp_npc = x[13:0]; end
      default: exp_npc = ret;
    endcase
    exp_q.push_back({n, exp_npc});
    @(negedge clk);
    check_eq("busy_resolve", 32'(spc_busy), 32'd1);
    disp_req = 1'b0;
    dr  = 1'b0;
    dp  = 1'b0;
    dn  = 1'b0;
    dpc = 14'h0;
    if (hold_push) begin
      spc_push  = 1'b1;
      spc_wdata = hd;
    end
    @(negedge clk);
    check_eq("latency_3", 32'(npc_valid), 32'd1);
    chk_state("disp");
  endtask

  task automatic ext_op(input bit pu, input bit po, input logic [18:0] d, input bit clr,
                        input string tag);
    logic [18:0] x;
    @(negedge clk);
    spc_push  = pu;
    spc_pop   = po;
    spc_wdata = d;
    err_clr   = clr;
    @(negedge clk);
    spc_push = 1'b0;
    spc_pop  = 1'b0;
    err_clr  = 1'b0;
    if (pu && po) begin
      mstack[msp] = d;
      mvalid[msp] = 1'b1;
    end else if (pu) begin
      m_push(d);
    end else if (po) begin
      m_pop(x);
    end
    if (clr) begin
      movf = 1'b0;
      munf = 1'b0;
    end
    chk_state(tag);
  endtask

  // Scoreboard consumer: every npc_valid pulse must match the oldest expectation
  always @(negedge clk) begin
    if (npc_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_valid", 32'(npc_valid), 32'd0);
      end else begin
        logic [14:0] e;
        e = exp_q.pop_front();
        check_eq("npc", 32'(npc), 32'(e[13:0]));
        check_eq("inhibit", 32'(inhibit), 32'(e[14]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      mstack[i] = '0;
      mvalid[i] = 1'b0;
    end
    reset     = 1'b0;
    disp_req  = 1'b0;
    pc        = '0;
    dr        = 1'b0;
    dp        = 1'b0;
    dn        = 1'b0;
    dpc       = '0;
    spc_push  = 1'b0;
    spc_pop   = 1'b0;
    spc_wdata = '0;
    err_clr   = 1'b0;
    m_reset();

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_state("reset");
    check_eq("reset_rdy", 32'(disp_ready), 32'd1);
    check_eq("reset_nv", 32'(npc_valid), 32'd0);
    check_eq("reset_npc", 32'(npc), 32'd0);
    check_eq("reset_inh", 32'(inhibit), 32'd0);

    // Call, then return, fall-through with pc wrap, plain jump
    dispatch(14'h0100, 1'b0, 1'b1, 1'b0, 14'h2A00, 1'b0, 19'h0);
    check_eq("call_top", 32'(spc_top), 32'h00101);
    check_eq("call_ptr", 32'(spc_ptr), 32'd0);
    dispatch(14'h0200, 1'b1, 1'b0, 1'b1, 14'h1234, 1'b0, 19'h0);
    check_eq("ret_ptr", 32'(spc_ptr), 32'd31);
    dispatch(14'h3FFF, 1'b1, 1'b1, 1'b0, 14'h0555, 1'b0, 19'h0);
    dispatch(14'h0055, 1'b0, 1'b0, 1'b1, 14'h0ABC, 1'b0, 19'h0);

    // Overflow: 33 external pushes
    for (int i = 0; i <= 32; i++) ext_op(1'b1, 1'b0, 19'(i), 1'b0, "push");
    check_eq("ovf_ptr", 32'(spc_ptr), 32'd0);
    check_eq("ovf_top", 32'(spc_top), 32'h00020);
    check_eq("ovf_flag", 32'(spc_ovf), 32'd1);

    // Underflow: 33 external pops
    for (int i = 0; i <= 32; i++) ext_op(1'b0, 1'b1, 19'h0, 1'b0, "pop");
    check_eq("unf_flag", 32'(spc_unf), 32'd1);

    // err_clr alone, then err_clr beating a same-cycle underflow
    ext_op(1'b0, 1'b0, 19'h0, 1'b1, "clr");
    ext_op(1'b0, 1'b1, 19'h0, 1'b1, "clr_pop");
    check_eq("clr_prio_unf", 32'(spc_unf), 32'd0);

    // Push held across RESOLVE: dropped while busy, accepted once idle
    dispatch(14'h0300, 1'b0, 1'b0, 1'b0, 14'h0400, 1'b1, 19'h07777);
    check_eq("drop_busy_ptr", 32'(spc_ptr), 32'(msp));
    @(negedge clk);
    spc_push = 1'b0;
    m_push(19'h07777);
    chk_state("held_push");

    // Simultaneous push and pop replaces the top
    ext_op(1'b1, 1'b1, 19'h1AAAA, 1'b0, "replace");
    check_eq("replace_top", 32'(spc_top), 32'h1AAAA);
    ext_op(1'b1, 1'b0, 19'h00ABC, 1'b0, "pre_rst_push");

    // Reset during WAIT abandons the dispatch
    @(negedge clk);
    disp_req = 1'b1;
    pc       = 14'h0010;
    @(negedge clk);
    disp_req = 1'b0;
    dr       = 1'b1;
    dp       = 1'b1;
    reset    = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    dr    = 1'b0;
    dp    = 1'b0;
    m_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("rst_wait_nv", 32'(npc_valid), 32'd0);
    end
    chk_state("rst_wait");

    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
